hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have a single clock and a reset: CLK  in  1  clock, rising edge; RESET  in  1  asynchronous, active-high reset.
REQ-002 The block SHALL have these inputs:
- ID_REG_READ_ADDR1, ID_REG_READ_ADDR2  in  5 each  source registers of the instruction in ID
- ID_USES_RS1, ID_USES_RS2  in  1 each  marks the matching source as actually read
- EX_REG_WRITE_ADDR  in  5  destination of the instruction in EX
- EX_DATA_MEM_READ  in  4  load control of EX; a nonzero value means a load
- EX_BRANCH_TAKEN  in  1  branch/jump redirect resolved in EX
- IMEM_BUSY  in  1  instruction fetch not yet complete
- DMEM_BUSY  in  1  data memory access in MEM not yet complete
- CNT_CLEAR  in  1  synchronous clear of the performance counters
REQ-003 The block SHALL have these outputs:
- PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL  out  1 each  hold the PC / named pipeline register
- IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH  out  1 each  load a bubble (all zero) into the named register
- STALL_COUNT, FLUSH_COUNT  out  32 each  performance counters
- STATE  out  2  current FSM state, for debug

Function
REQ-004 The FSM SHALL have four states: RUN=0, MEM_WAIT=1, FETCH_WAIT=2, REDIRECT_PEND=3.
REQ-005 The stall and flush outputs SHALL be combinational functions of the current state and inputs (Mealy), so they are valid in the cycle in which the condition is present.
REQ-006 A load-use hazard SHALL be true when all of the following hold: EX_DATA_MEM_READ is nonzero; EX_REG_WRITE_ADDR is nonzero; and EX_REG_WRITE_ADDR equals ID_REG_READ_ADDR1 with ID_USES_RS1 = 1, or equals ID_REG_READ_ADDR2 with ID_USES_RS2 = 1.
REQ-007 In RUN, conditions SHALL be evaluated in fixed priority order; the first true condition applies and no lower-priority condition acts in that cycle:
- (1) DMEM_BUSY: assert PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL and MEM_WB_FLUSH; ignore EX_BRANCH_TAKEN; next state MEM_WAIT.
- (2) EX_BRANCH_TAKEN with IMEM_BUSY = 0: assert IF_ID_FLUSH and ID_EX_FLUSH; remain in RUN.
- (3) EX_BRANCH_TAKEN with IMEM_BUSY = 1: assert IF_ID_FLUSH, ID_EX_FLUSH and PC_STALL; next state REDIRECT_PEND.
- (4) load-use hazard: assert PC_STALL, IF_ID_STALL and ID_EX_FLUSH for exactly this cycle; remain in RUN.
- (5) IMEM_BUSY: assert PC_STALL and IF_ID_FLUSH; next state FETCH_WAIT.
- Otherwise: all stall and flush outputs SHALL be 0.
REQ-008 MEM_WAIT SHALL keep the freeze outputs of REQ-007(1) asserted while DMEM_BUSY = 1.
REQ-009 When DMEM_BUSY falls in MEM_WAIT, the block SHALL re-evaluate REQ-007 as if in RUN in that same cycle; a branch frozen in EX is then honoured.
REQ-010 FETCH_WAIT SHALL behave as follows:
- While IMEM_BUSY = 1, assert PC_STALL and IF_ID_FLUSH.
- DMEM_BUSY and EX_BRANCH_TAKEN keep the priority and transitions of REQ-007(1) and REQ-007(3).
- When IMEM_BUSY = 0, return to RUN.
REQ-011 REDIRECT_PEND SHALL behave as follows:
- While IMEM_BUSY = 1, assert PC_STALL and IF_ID_FLUSH.
- In the first cycle with IMEM_BUSY = 0, assert IF_ID_FLUSH once more to discard the stale fetched instruction, then go to RUN.
- DMEM_BUSY has priority and sends the FSM to MEM_WAIT; the redirect flag SHALL be kept and REDIRECT_PEND re-entered afterwards.
REQ-012 A stall and a flush of the same register SHALL never both be asserted; flush wins.
REQ-013 STALL_COUNT SHALL increment by 1 in each cycle in which PC_STALL = 1.
REQ-014 FLUSH_COUNT SHALL increment by 1 in each cycle in which IF_ID_FLUSH or ID_EX_FLUSH is 1.
REQ-015 Both counters SHALL wrap from 0xFFFFFFFF to 0; CNT_CLEAR SHALL zero them and has priority over an increment in the same cycle.

Reset
REQ-016 RESET SHALL asynchronously force: STATE = RUN; redirect flag = 0; STALL_COUNT = FLUSH_COUNT = 0.
REQ-017 During RESET, all stall and flush outputs SHALL be 0.
REQ-018 A reset asserted mid-wait SHALL abandon any pending redirect.

Structure
REQ-019 The state encodings and the counter width (32) SHALL be defined in a shared package (cpu_ctrl_pkg).
REQ-020 The counters SHALL be one sub-module, perf_counter, instantiated twice.
REQ-021 Hazard comparison and the FSM SHALL live in hazard_ctrl.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Load-use: EX_DATA_MEM_READ = 4'b0010, EX_REG_WRITE_ADDR = 5, ID_REG_READ_ADDR2 = 5, ID_USES_RS2 = 1 -> PC_STALL = IF_ID_STALL = ID_EX_FLUSH = 1 for one cycle; STALL_COUNT = 1.
- Same as above but EX_REG_WRITE_ADDR = 0 or ID_USES_RS2 = 0 -> no stall.
- DMEM_BUSY = 1 for 3 cycles with EX_BRANCH_TAKEN = 1 -> full freeze for 3 cycles, STATE = 1; in the 4th cycle IF_ID_FLUSH = ID_EX_FLUSH = 1.
- EX_BRANCH_TAKEN = 1 with IMEM_BUSY = 1 for 2 cycles -> STATE = 3; IF_ID_FLUSH asserted for 3 consecutive cycles; then STATE = 0.
- RESET pulsed while in REDIRECT_PEND -> STATE = 0 and both counters = 0 immediately; no further flush after reset.
- Preload STALL_COUNT = 0xFFFFFFFF, then one stall cycle -> STALL_COUNT = 0; CNT_CLEAR together with a stall -> 0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller: FSM state
// encoding, counter width, and the bundle of stall/flush controls.
package cpu_ctrl_pkg;

    localparam int CNT_W      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int MEM_CTRL_W = 4;

    // Debug-visible encoding; the values are part of the STATE output contract.
    typedef enum logic [1:0] {
        ST_RUN           = 2'd0,
        ST_MEM_WAIT      = 2'd1,
        ST_FETCH_WAIT    = 2'd2,
        ST_REDIRECT_PEND = 2'd3
    } hz_state_e;

    // One bit per pipeline control line driven by the hazard unit.
    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic id_ex_stall;
        logic ex_mem_stall;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
    } hz_ctrl_t;

    // Result of evaluating one cycle: controls plus where the FSM goes next.
    typedef struct packed {
        hz_state_e next_state;
        logic      redirect;
        hz_ctrl_t  ctrl;
    } hz_step_t;

    localparam hz_ctrl_t CTRL_IDLE = '0;

    // Whole-pipe freeze while the data memory is busy; the instruction in MEM
    // is held, so a bubble goes into MEM/WB.
    localparam hz_ctrl_t CTRL_FREEZE = '{
        pc_stall:     1'b1,
        if_id_stall:  1'b1,
        id_ex_stall:  1'b1,
        ex_mem_stall: 1'b1,
        if_id_flush:  1'b0,
        id_ex_flush:  1'b0,
        mem_wb_flush: 1'b1
    };

    // A register that is both held and bubbled takes the bubble.
    function automatic hz_ctrl_t resolve_conflicts(input hz_ctrl_t c);
        hz_ctrl_t r;
        r             = c;
        r.if_id_stall = c.if_id_stall & ~c.if_id_flush;
        r.id_ex_stall = c.id_ex_stall & ~c.id_ex_flush;
        return r;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: the ID/EX/memory status the
// unit observes and the stall/flush lines it drives back into the pipeline.
interface hazard_ctrl_if;
    import cpu_ctrl_pkg::*;

    logic [REG_ADDR_W-1:0] ID_REG_READ_ADDR1;
    logic [REG_ADDR_W-1:0] ID_REG_READ_ADDR2;
    logic                  ID_USES_RS1;
    logic                  ID_USES_RS2;
    logic [REG_ADDR_W-1:0] EX_REG_WRITE_ADDR;
    logic [MEM_CTRL_W-1:0] EX_DATA_MEM_READ;
    logic                  EX_BRANCH_TAKEN;
    logic                  IMEM_BUSY;
    logic                  DMEM_BUSY;

    logic                  PC_STALL;
    logic                  IF_ID_STALL;
    logic                  ID_EX_STALL;
    logic                  EX_MEM_STALL;
    logic                  IF_ID_FLUSH;
    logic                  ID_EX_FLUSH;
    logic                  MEM_WB_FLUSH;

    // Pipeline datapath side.
    modport master (
        output ID_REG_READ_ADDR1, ID_REG_READ_ADDR2, ID_USES_RS1, ID_USES_RS2,
        output EX_REG_WRITE_ADDR, EX_DATA_MEM_READ, EX_BRANCH_TAKEN,
        output IMEM_BUSY, DMEM_BUSY,
        input  PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL,
        input  IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH
    );

    // Hazard controller side.
    modport slave (
        input  ID_REG_READ_ADDR1, ID_REG_READ_ADDR2, ID_USES_RS1, ID_USES_RS2,
        input  EX_REG_WRITE_ADDR, EX_DATA_MEM_READ, EX_BRANCH_TAKEN,
        input  IMEM_BUSY, DMEM_BUSY,
        output PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL,
        output IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH
    );

endinterface

// File: rtl/perf_counter.sv
// Free-running event counter with synchronous clear; wraps at full scale.
module perf_counter
    import cpu_ctrl_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    // Count qualifying cycles; clear wins over a simultaneous increment.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: detects load-use hazards, sequences memory and
// fetch waits and branch redirects, and drives Mealy stall/flush controls.
module hazard_ctrl
    import cpu_ctrl_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    hazard_ctrl_if.slave     hz,
    input  logic             CNT_CLEAR,
    output logic [CNT_W-1:0] STALL_COUNT,
    output logic [CNT_W-1:0] FLUSH_COUNT,
    output logic [1:0]       STATE
);

    hz_state_e state_q;
    logic      redirect_q;
    logic      load_use;
    hz_step_t  step;
    hz_ctrl_t  ctrl;

    // Normal priority ladder; also used by FETCH_WAIT and on leaving MEM_WAIT.
    function automatic hz_step_t eval_run(input logic dmem_busy,
                                          input logic imem_busy,
                                          input logic branch_taken,
                                          input logic hazard);
        hz_step_t s;
        s.next_state = ST_RUN;
        s.redirect   = 1'b0;
        s.ctrl       = CTRL_IDLE;
        if (dmem_busy) begin
            s.ctrl       = CTRL_FREEZE;
            s.next_state = ST_MEM_WAIT;
        end else if (branch_taken && !imem_busy) begin
            s.ctrl.if_id_flush = 1'b1;
            s.ctrl.id_ex_flush = 1'b1;
        end else if (branch_taken) begin
            // Redirect target not fetchable yet: remember it and hold the PC.
            s.ctrl.if_id_flush = 1'b1;
            s.ctrl.id_ex_flush = 1'b1;
            s.ctrl.pc_stall    = 1'b1;
            s.next_state       = ST_REDIRECT_PEND;
            s.redirect         = 1'b1;
        end else if (hazard) begin
            s.ctrl.pc_stall    = 1'b1;
            s.ctrl.if_id_stall = 1'b1;
            s.ctrl.id_ex_flush = 1'b1;
        end else if (imem_busy) begin
            s.ctrl.pc_stall    = 1'b1;
            s.ctrl.if_id_flush = 1'b1;
            s.next_state       = ST_FETCH_WAIT;
        end
        return s;
    endfunction

    // Outstanding redirect: wait out the fetch, then drop the stale fetch once.
    function automatic hz_step_t eval_redirect(input logic dmem_busy,
                                               input logic imem_busy);
        hz_step_t s;
        s.next_state       = ST_REDIRECT_PEND;
        s.redirect         = 1'b1;
        s.ctrl             = CTRL_IDLE;
        s.ctrl.if_id_flush = 1'b1;
        if (dmem_busy) begin
            // Freeze overrides; the redirect flag survives the memory wait.
            s.ctrl       = CTRL_FREEZE;
            s.next_state = ST_MEM_WAIT;
        end else if (imem_busy) begin
            s.ctrl.pc_stall = 1'b1;
        end else begin
            s.next_state = ST_RUN;
            s.redirect   = 1'b0;
        end
        return s;
    endfunction

    // Hazard detection and per-state selection of this cycle's controls.
    // NOTE: every always_comb output gets a value on every path, so no latch.
    always_comb begin
        load_use = (hz.EX_DATA_MEM_READ != '0)
                && (hz.EX_REG_WRITE_ADDR != '0)
                && (((hz.EX_REG_WRITE_ADDR == hz.ID_REG_READ_ADDR1) && hz.ID_USES_RS1)
                 || ((hz.EX_REG_WRITE_ADDR == hz.ID_REG_READ_ADDR2) && hz.ID_USES_RS2));

        step = eval_run(hz.DMEM_BUSY, hz.IMEM_BUSY, hz.EX_BRANCH_TAKEN, load_use);
        case (state_q)
            ST_RUN, ST_FETCH_WAIT: begin
                step = eval_run(hz.DMEM_BUSY, hz.IMEM_BUSY, hz.EX_BRANCH_TAKEN, load_use);
            end
            ST_MEM_WAIT: begin
                // Once memory frees up, resume whatever was interrupted.
                if (redirect_q) begin
                    step = eval_redirect(hz.DMEM_BUSY, hz.IMEM_BUSY);
                end else begin
                    step = eval_run(hz.DMEM_BUSY, hz.IMEM_BUSY, hz.EX_BRANCH_TAKEN, load_use);
                end
            end
            ST_REDIRECT_PEND: begin
                step = eval_redirect(hz.DMEM_BUSY, hz.IMEM_BUSY);
            end
            default: begin
                step = eval_run(hz.DMEM_BUSY, hz.IMEM_BUSY, hz.EX_BRANCH_TAKEN, load_use);
            end
        endcase

        // Controls are quiet while reset is held.
        ctrl = RESET ? CTRL_IDLE : resolve_conflicts(step.ctrl);
    end

    // FSM state and redirect flag; reset abandons any pending redirect.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_RUN;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= step.next_state;
            redirect_q <= step.redirect;
        end
    end

    assign hz.PC_STALL     = ctrl.pc_stall;
    assign hz.IF_ID_STALL  = ctrl.if_id_stall;
    assign hz.ID_EX_STALL  = ctrl.id_ex_stall;
    assign hz.EX_MEM_STALL = ctrl.ex_mem_stall;
    assign hz.IF_ID_FLUSH  = ctrl.if_id_flush;
    assign hz.ID_EX_FLUSH  = ctrl.id_ex_flush;
    assign hz.MEM_WB_FLUSH = ctrl.mem_wb_flush;
    assign STATE           = state_q;

    perf_counter #(.WIDTH(CNT_W)) u_stall_count (
        .CLK   (CLK),
        .RESET (RESET),
        .clear (CNT_CLEAR),
        .inc   (ctrl.pc_stall),
        .count (STALL_COUNT)
    );

    perf_counter #(.WIDTH(CNT_W)) u_flush_count (
        .CLK   (CLK),
        .RESET (RESET),
        .clear (CNT_CLEAR),
        .inc   (ctrl.if_id_flush | ctrl.id_ex_flush),
        .count (FLUSH_COUNT)
    );

endmodule
